// File: rtl/window_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : window_pkg
//  Description : Shared constants for the 3x3 sliding-window generator.
//                Tap k = WIN_DIM*row + col, with row 0 = oldest (top) line
//                and col 0 = oldest (left) column.
//  Revision    : 1.0 - initial release
// ============================================================================
package window_pkg;

    // Window edge length and total tap count
    localparam int WIN_DIM  = 3;
    localparam int NUM_TAPS = WIN_DIM * WIN_DIM;

    // Tap indices, row-major from the top-left (oldest) sample
    localparam int TAP_TL = 0;
    localparam int TAP_TC = 1;
    localparam int TAP_TR = 2;
    localparam int TAP_ML = 3;
    localparam int TAP_MC = 4;
    localparam int TAP_MR = 5;
    localparam int TAP_BL = 6;
    localparam int TAP_BC = 7;
    localparam int TAP_BR = 8;

    // Flat tap index from a (window row, window column) pair
    function automatic int tap_idx(input int wr, input int wc);
        return wr * WIN_DIM + wc;
    endfunction

endpackage : window_pkg
`default_nettype wire

// File: rtl/line_mem.sv
`default_nettype none
// ============================================================================
//  Module      : line_mem
//  Description : Single-port line buffer, one entry per pixel column.
//                The read port is asynchronous, so a read and a write to the
//                same address in one cycle return the old contents
//                (read-before-write). Contents are deliberately not reset:
//                the window generator never lets a stale entry reach a
//                valid window.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Old contents are visible for the whole cycle in which they get replaced
    assign o_rdata = mem_q[i_addr];

    // Write the new sample at the addressed column
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_addr] <= i_wdata;
        end
    end

endmodule : line_mem
`default_nettype wire

// File: rtl/window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : window_gen
//  Description : Streaming 3x3 window generator. Pixels arrive in raster
//                order over a valid/ready handshake; two line buffers hold
//                the previous two lines so that every pixel at column >= 2
//                and row >= 2 emits a full window centred one pixel up and
//                one pixel left. Output is registered with one cycle of
//                latency and fully back-pressured by ready_in.
//                Optional build macro WINDOW_COORD_EN adds win_x / win_y
//                ports carrying the window-centre coordinates.
//  Revision    : 1.0 - initial release
// ============================================================================
module window_gen
    import window_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int NUM_CH     = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0]          pixel_in,
    input  logic                                  valid_in,
    input  logic                                  sof_in,
    output logic                                  ready_out,
    output logic [NUM_TAPS*NUM_CH*DATA_WIDTH-1:0] win_out,
    output logic                                  valid_out,
    input  logic                                  ready_in,
    output logic                                  eof_out,
    output logic                                  sof_err
`ifdef WINDOW_COORD_EN
    ,
    output logic [$clog2(IMG_WIDTH)-1:0]          win_x,
    output logic [$clog2(IMG_HEIGHT)-1:0]         win_y
`endif
);

    localparam int PIX_W = NUM_CH * DATA_WIDTH;
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    localparam logic [COL_W-1:0] c_col_last = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] c_row_last = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] c_col_edge = COL_W'(WIN_DIM - 1);
    localparam logic [ROW_W-1:0] c_row_edge = ROW_W'(WIN_DIM - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             valid_q, valid_d;
    logic             eof_q, eof_d;
    logic             sof_err_q, sof_err_d;
    logic [PIX_W-1:0] win_q [NUM_TAPS];
    logic [PIX_W-1:0] win_d [NUM_TAPS];

    // ------------------------------------------------------------------
    // Handshake and effective position
    // ------------------------------------------------------------------
    logic             w_accept;
    logic             w_sof_take;
    logic [COL_W-1:0] w_eff_col;
    logic [ROW_W-1:0] w_eff_row;
    logic             w_qualify;
    logic             w_last_pix;
    logic [PIX_W-1:0] w_line1_rd;
    logic [PIX_W-1:0] w_line2_rd;

    // Upstream may push whenever the output slot is empty or being drained
    assign ready_out = !valid_q || ready_in;
    assign w_accept  = valid_in && ready_out;

    // A start-of-frame marker forces the accepted pixel to (0,0)
    always_comb begin
        w_sof_take = w_accept && sof_in;
        w_eff_col  = w_sof_take ? '0 : col_q;
        w_eff_row  = w_sof_take ? '0 : row_q;
        w_qualify  = (w_eff_col >= c_col_edge) && (w_eff_row >= c_row_edge);
        w_last_pix = (w_eff_col == c_col_last) && (w_eff_row == c_row_last);
    end

    // ------------------------------------------------------------------
    // Line buffers: line1 holds the previous line, line2 the one before.
    // On accept line2 inherits line1's old entry and line1 takes the pixel.
    // ------------------------------------------------------------------
    line_mem #(
        .WIDTH (PIX_W),
        .DEPTH (IMG_WIDTH)
    ) u_line1 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (w_eff_col),
        .i_wdata (pixel_in),
        .o_rdata (w_line1_rd)
    );

    line_mem #(
        .WIDTH (PIX_W),
        .DEPTH (IMG_WIDTH)
    ) u_line2 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (w_eff_col),
        .i_wdata (w_line1_rd),
        .o_rdata (w_line2_rd)
    );

    // Raster position advances on every accepted pixel, wrapping per line/frame
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (w_accept) begin
            if (w_eff_col == c_col_last) begin
                col_d = '0;
                row_d = (w_eff_row == c_row_last) ? '0 : w_eff_row + ROW_W'(1);
            end else begin
                col_d = w_eff_col + COL_W'(1);
                row_d = w_eff_row;
            end
        end
    end

    // Output qualification: set by a window-producing accept, dropped once
    // the window is consumed, held while downstream stalls
    always_comb begin
        valid_d   = valid_q;
        eof_d     = eof_q;
        sof_err_d = w_sof_take && ((col_q != '0) || (row_q != '0));
        if (w_accept) begin
            valid_d = w_qualify;
            eof_d   = w_qualify && w_last_pix;
        end else if (ready_in) begin
            valid_d = 1'b0;
            eof_d   = 1'b0;
        end
    end

    // Window shifts one column left on accept; the new right column is
    // {two lines back, one line back, current pixel} from top to bottom
    always_comb begin
        win_d = win_q;
        if (w_accept) begin
            for (int wr = 0; wr < WIN_DIM; wr++) begin
                for (int wc = 0; wc < WIN_DIM - 1; wc++) begin
                    win_d[tap_idx(wr, wc)] = win_q[tap_idx(wr, wc + 1)];
                end
            end
            win_d[TAP_TR] = w_line2_rd;
            win_d[TAP_MR] = w_line1_rd;
            win_d[TAP_BR] = pixel_in;
        end
    end

    // Register all state; line buffers are intentionally left out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            valid_q   <= 1'b0;
            eof_q     <= 1'b0;
            sof_err_q <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            valid_q   <= valid_d;
            eof_q     <= eof_d;
            sof_err_q <= sof_err_d;
            win_q     <= win_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign valid_out = valid_q;
    assign eof_out   = eof_q;
    assign sof_err   = sof_err_q;

    // Flatten taps; channels of a tap are already packed in pixel order
    genvar k;
    generate
        for (k = 0; k < NUM_TAPS; k++) begin : g_pack
            assign win_out[k*PIX_W +: PIX_W] = win_q[k];
        end
    endgenerate

`ifdef WINDOW_COORD_EN
    // ------------------------------------------------------------------
    // Window-centre coordinates, updated together with the window taps
    // ------------------------------------------------------------------
    logic [COL_W-1:0] win_x_q, win_x_d;
    logic [ROW_W-1:0] win_y_q, win_y_d;

    // Centre sits one column left and one row up from the producing pixel
    always_comb begin
        win_x_d = win_x_q;
        win_y_d = win_y_q;
        if (w_accept && w_qualify) begin
            win_x_d = w_eff_col - COL_W'(1);
            win_y_d = w_eff_row - ROW_W'(1);
        end
    end

    // Coordinate registers share the window's reset and hold behaviour
    always_ff @(posedge clk) begin
        if (rst) begin
            win_x_q <= '0;
            win_y_q <= '0;
        end else begin
            win_x_q <= win_x_d;
            win_y_q <= win_y_d;
        end
    end

    assign win_x = win_x_q;
    assign win_y = win_y_q;
`endif

endmodule : window_gen
`default_nettype wire

// File: tb/tb_window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_window_gen
//  Description : Self-checking bench for window_gen (W=8, H=6, one 8-bit
//                channel). A reference model stores each frame as a 2-D
//                image and builds the expected 3x3 window for every pixel
//                at column >= 2 and row >= 2; a monitor compares every
//                consumed window against the queued expectation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_window_gen;

    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int NC = 1;
    localparam int WW = 9 * NC * DW;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic [DW-1:0] pixel_in = '0;
    logic          valid_in = 1'b0;
    logic          sof_in   = 1'b0;
    logic          ready_in = 1'b1;
    logic          ready_out;
    logic [WW-1:0] win_out;
    logic          valid_out;
    logic          eof_out;
    logic          sof_err;
`ifdef WINDOW_COORD_EN
    logic [2:0]    win_x;
    logic [2:0]    win_y;
`endif

    window_gen #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .NUM_CH     (NC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pixel_in  (pixel_in),
        .valid_in  (valid_in),
        .sof_in    (sof_in),
        .ready_out (ready_out),
        .win_out   (win_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .eof_out   (eof_out),
        .sof_err   (sof_err)
`ifdef WINDOW_COORD_EN
        ,
        .win_x     (win_x),
        .win_y     (win_y)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WW-1:0] win;
        logic          eof;
        int            x;
        int            y;
    } win_t;

    typedef struct {
        logic serr;
        logic rst;
    } cyc_t;

    win_t          wq[$];
    cyc_t          cq[$];
    int            n_cmp        = 0;
    int            n_mis        = 0;
    int            mx           = 0;
    int            my           = 0;
    int            exp_windows  = 0;
    int            seen_windows = 0;
    logic [DW-1:0] img [H][W];

    logic          prev_stall = 1'b0;
    logic [WW-1:0] prev_win   = '0;
    logic          prev_eof   = 1'b0;

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame as an image, windows cut straight from it
    task automatic model_cycle(input logic acc, input logic [DW-1:0] p, input logic s, input logic r);
        cyc_t c;
        win_t w;
        int   x;
        int   y;
        c.serr = 1'b0;
        c.rst  = r;
        if (r) begin
            mx = 0;
            my = 0;
            exp_windows -= wq.size();
            wq.delete();
        end else if (acc) begin
            x      = s ? 0 : mx;
            y      = s ? 0 : my;
            c.serr = s && (mx != 0 || my != 0);
            img[y][x] = p;
            if (x >= 2 && y >= 2) begin
                w.win = '0;
                for (int wr = 0; wr < 3; wr++)
                    for (int wc = 0; wc < 3; wc++)
                        w.win[(3*wr+wc)*DW +: DW] = img[y-2+wr][x-2+wc];
                w.eof = (x == W-1) && (y == H-1);
                w.x   = x - 1;
                w.y   = y - 1;
                wq.push_back(w);
                exp_windows++;
            end
            x++;
            if (x == W) begin
                x = 0;
                y = (y == H-1) ? 0 : y + 1;
            end
            mx = x;
            my = y;
        end
        cq.push_back(c);
    endtask

    // One clock of stimulus; the accept decision is taken mid-cycle
    task automatic step(input logic v, input logic [DW-1:0] p, input logic s,
                        input logic rdy, input logic r, output logic acc);
        @(posedge clk);
        #1;
        valid_in = v;
        pixel_in = p;
        sof_in   = s;
        ready_in = rdy;
        rst      = r;
        @(negedge clk);
        acc = v && (ready_out === 1'b1) && !r;
        model_cycle(acc, p, s, r);
    endtask

    task automatic send_pixel(input logic [DW-1:0] p, input logic s, input logic rnd);
        logic acc;
        int   tries;
        tries = 0;
        acc   = 1'b0;
        if (rnd && $urandom_range(0, 2) == 0)
            repeat ($urandom_range(1, 3)) step(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, acc);
        acc = 1'b0;
        while (!acc) begin
            step(1'b1, p, s, rnd ? ($urandom_range(0, 2) != 0) : 1'b1, 1'b0, acc);
            tries++;
            if (!acc && tries >= 200) begin
                n_cmp++;
                n_mis++;
                $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
                return;
            end
        end
    endtask

    // mode 0: pixel = row*16+col, mode 1: random data
    task automatic send_frame(input int mode, input logic rnd, input logic sof_first,
                              input int start, input int count, input int stall_idx);
        logic          acc;
        logic [DW-1:0] p;
        int            x;
        int            y;
        for (int i = start; i < start + count; i++) begin
            x = i % W;
            y = i / W;
            p = (mode == 0) ? 8'(y * 16 + x) : 8'($urandom);
            if (i == stall_idx)
                repeat (3) step(1'b1, p, 1'b0, 1'b0, 1'b0, acc);
            send_pixel(p, sof_first && (i == start), rnd);
        end
    endtask

    // Monitor: per-cycle checks plus window scoreboard on consumption
    initial begin
        cyc_t c;
        win_t w;
        forever begin
            @(posedge clk);
            #3;
            if (cq.size() > 0) c = cq.pop_front();
            else begin
                c.serr = 1'b0;
                c.rst  = 1'b0;
            end
            if (c.rst) begin
                check("rst_valid_out", WW'(valid_out), WW'(0));
                check("rst_win_out", win_out, WW'(0));
                check("rst_eof_out", WW'(eof_out), WW'(0));
            end else if (prev_stall) begin
                check("hold_valid_out", WW'(valid_out), WW'(1));
                check("hold_win_out", win_out, prev_win);
                check("hold_eof_out", WW'(eof_out), WW'(prev_eof));
            end
            check("sof_err", WW'(sof_err), WW'(c.serr));
            check("ready_out", WW'(ready_out), WW'(!valid_out || ready_in));
            if (valid_out === 1'b1 && ready_in) begin
                if (wq.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL unexpected_window: got %0h expected no window", win_out);
                end else begin
                    w = wq.pop_front();
                    seen_windows++;
                    check("win_out", win_out, w.win);
                    check("eof_out", WW'(eof_out), WW'(w.eof));
`ifdef WINDOW_COORD_EN
                    check("win_x", WW'(win_x), WW'(w.x));
                    check("win_y", WW'(win_y), WW'(w.y));
`endif
                end
            end
            prev_stall = (valid_out === 1'b1) && !ready_in;
            prev_win   = win_out;
            prev_eof   = eof_out;
        end
    end

    initial begin
        logic a;
        repeat (3) step(1'b0, '0, 1'b0, 1'b1, 1'b1, a);
        // Counting-pattern frame, continuous flow
        send_frame(0, 1'b0, 1'b0, 0, W*H, -1);
        // Same pattern with sof, stalled three cycles on the first window
        send_frame(0, 1'b0, 1'b1, 0, W*H, 19);
        // Misplaced sof at position (3,2), then a full frame from there
        send_frame(0, 1'b0, 1'b0, 0, 19, -1);
        send_frame(0, 1'b0, 1'b1, 0, W*H, -1);
        send_frame(0, 1'b0, 1'b0, 0, W*H, -1);
        // Reset after 20 pixels, then a clean frame
        send_frame(0, 1'b0, 1'b0, 0, 20, -1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1, a);
        send_frame(0, 1'b0, 1'b0, 0, W*H, -1);
        // Random data with random gaps and back-pressure
        for (int f = 0; f < 4; f++)
            send_frame(1, 1'b1, 1'($urandom), 0, W*H, -1);
        repeat (5) step(1'b0, '0, 1'b0, 1'b1, 1'b0, a);
        check("window_total", WW'(seen_windows), WW'(exp_windows));
        check("queue_empty", WW'(wq.size()), WW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_window_gen
`default_nettype wire

// File: doc/window_gen.md
WINDOW_GEN -- requirements
Module: window_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per channel sample.
REQ-002 SHALL have parameter IMG_WIDTH, default 8, pixels per line; IMG_WIDTH >= 3.
REQ-003 SHALL have parameter IMG_HEIGHT, default 8, lines per frame; IMG_HEIGHT >= 3.
REQ-004 SHALL have parameter NUM_CH, default 1, channels packed per pixel.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk  input  1  sole clock; all logic on posedge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 pixel_in  input  NUM_CH*DATA_WIDTH  pixel; channel c at [c*DATA_WIDTH +: DATA_WIDTH].
REQ-009 valid_in  input  1  pixel_in valid.
REQ-010 sof_in  input  1  qualifies the accepted pixel as frame pixel (0,0).
REQ-011 ready_out  output  1  block can accept a pixel.
REQ-012 win_out  output  9*NUM_CH*DATA_WIDTH  3x3 window; tap k=3*wr+wc (wr 0=top/oldest line, wc 0=left/oldest column), channel c at [(k*NUM_CH+c)*DATA_WIDTH +: DATA_WIDTH].
REQ-013 valid_out  output  1  win_out valid.
REQ-014 ready_in  input  1  downstream accepts window.
REQ-015 eof_out  output  1  current window is the frame's last.
REQ-016 sof_err  output  1  one-cycle pulse: sof_in accepted while position != (0,0).

Function
REQ-017 Pixel accepted iff valid_in && ready_out; window consumed iff valid_out && ready_in.
REQ-018 ready_out SHALL equal !valid_out || ready_in (combinational, no path from valid_in).
REQ-019 Column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) SHALL advance on each accept; col wraps to 0 incrementing row; row wraps to 0 after (IMG_WIDTH-1, IMG_HEIGHT-1).
REQ-020 Two line memories (IMG_WIDTH entries, NUM_CH*DATA_WIDTH wide) addressed by col; on accept: read line1[col], line2[col], then line2[col] <= line1[col], line1[col] <= pixel_in.
REQ-021 On accept, window columns SHALL shift left; new right column = {line2[col], line1[col], pixel_in} (top, middle, bottom).
REQ-022 valid_out SHALL be set the cycle after an accept at row >= 2 and col >= 2; cleared after consumption with no new qualifying accept; latency 1 cycle.
REQ-023 While valid_out && !ready_in, win_out, eof_out and valid_out SHALL hold stable.
REQ-024 Window produced by pixel (col,row) SHALL have centre (col-1,row-1); exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame; no windows spanning line or frame boundaries.
REQ-025 eof_out SHALL assert with the window from pixel (IMG_WIDTH-1, IMG_HEIGHT-1), same qualification as valid_out.
REQ-026 Accept with sof_in=1 SHALL treat pixel as (0,0), next position (1,0); if position was not (0,0), sof_err pulses one cycle after accept.
REQ-027 sof_in ignored when no accept occurs.

Reset
REQ-028 On rst: col, row = 0; valid_out, eof_out, sof_err = 0; win_out = 0; ready_out follows REQ-018 (= 1).
REQ-029 Line memories SHALL NOT be reset; stale contents never reach a valid window.
REQ-030 Reset mid-frame SHALL discard the partial frame; next accepted pixel is (0,0).

Configuration
REQ-031 Macro WINDOW_COORD_EN defined: SHALL add outputs win_x ($clog2(IMG_WIDTH) bits) and win_y ($clog2(IMG_HEIGHT) bits) giving window centre, reset 0, held with win_out.
REQ-032 Macro WINDOW_COORD_EN undefined: ports and logic absent; all else identical.

Structure
REQ-033 Shared package window_pkg SHALL hold tap index constants (TAP_TL..TAP_BR, 0..8) and window size constant WIN_DIM = 3.
REQ-034 Line memories SHALL be one sub-module line_mem (single-port read-before-write, IMG_WIDTH deep), instantiated twice.

Verification (W=8, H=6, NUM_CH=1, pixel = row*16+col, ready_in=1 unless stated)
REQ-035 Stream one frame -> first valid_out after pixel 0x22; win_out taps = 00,01,02,10,11,12,20,21,22; 24 windows total.
REQ-036 Same frame -> eof_out only with window from pixel 0x57, centre taps 0x46 at k=4; eof_out=0 on the other 23.
REQ-037 Deassert ready_in 3 cycles at first valid window -> win_out stable, ready_out=0, no pixel lost; subsequent window centre 0x12.
REQ-038 sof_in with pixel at position (3,2) -> sof_err=1 one cycle; following frame yields correct 24 windows.
REQ-039 rst after 20 pixels -> valid_out=0 next cycle; new frame output matches REQ-035.
REQ-040 WINDOW_COORD_EN build -> first window win_x=1, win_y=1; last win_x=6, win_y=4.
